// File: rtl/mem_store_pkg.sv
// Shared types for the store write buffer: default entry layout, FSM states and count width.
package mem_store_pkg;

  localparam int unsigned DEF_M = 32;
  localparam int unsigned DEF_A = 32;

  typedef struct packed {
    logic [DEF_A-1:0]   addr;
    logic [DEF_M-1:0]   data;
    logic [DEF_M/8-1:0] be;
  } store_entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  function automatic int unsigned CNT_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_store_writer_fifo.sv
// store_fifo: DEPTH-entry circular buffer of store entries; STORE_FWD_EN adds an age-ordered view.
module store_fifo
  import mem_store_pkg::*;
#(
  parameter type         T     = store_entry_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W(DEPTH)-1:0]    count
`ifdef STORE_FWD_EN
  ,
  output T [DEPTH-1:0]               ord
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = CNT_W(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

`ifdef STORE_FWD_EN
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) ord[i] = mem[rptr + PW'(i)];
  end
`endif

endmodule

// File: rtl/mem_store_writer.sv
// mem_store_writer: buffers MEM-stage stores and drains them to data memory via req/ack.
// Optional macro STORE_FWD_EN adds store-to-load forwarding ports (ld_addr/fwd_*).
module mem_store_writer
  import mem_store_pkg::*;
#(
  parameter int unsigned M     = 32,
  parameter int unsigned A     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [A-1:0]            st_addr,
  input  logic [M-1:0]            st_data,
  input  logic [M/8-1:0]          st_be,
  output logic                    mem_req,
  output logic [A-1:0]            mem_addr,
  output logic [M-1:0]            mem_wdata,
  output logic [M/8-1:0]          mem_be,
  input  logic                    mem_ack,
  output logic [CNT_W(DEPTH)-1:0] count,
  output logic                    empty
`ifdef STORE_FWD_EN
  ,
  input  logic [A-1:0]            ld_addr,
  output logic                    fwd_hit,
  output logic [M-1:0]            fwd_data,
  output logic [M/8-1:0]          fwd_be
`endif
);

  localparam int unsigned CW = CNT_W(DEPTH);

  typedef struct packed {
    logic [A-1:0]   addr;
    logic [M-1:0]   data;
    logic [M/8-1:0] be;
  } entry_t;

  state_t          state, state_nx;
  entry_t          wr, head;
  logic            push, pop, full, fifo_empty;
  logic [CW-1:0]   cnt_nx;

  assign st_ready = !full;
  assign push     = st_valid && st_ready && (st_be != '0);
  assign pop      = (state == REQ) && mem_ack;
  assign cnt_nx   = count - CW'(pop) + CW'(push);
  assign wr       = '{addr: st_addr, data: st_data, be: st_be};

`ifdef STORE_FWD_EN
  entry_t [DEPTH-1:0] ord;
`endif

  store_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (wr),
    .head  (head),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
`ifdef STORE_FWD_EN
    ,
    .ord   (ord)
`endif
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // IDLE looks at the registered count so mem_req trails the first enqueue by a cycle;
  // REQ looks ahead so a back-to-back drain keeps mem_req high.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (count != '0) state_nx = REQ;
      REQ:  if (mem_ack && (cnt_nx == '0)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req   = (state == REQ);
  assign mem_addr  = mem_req ? head.addr : '0;
  assign mem_wdata = mem_req ? head.data : '0;
  assign mem_be    = mem_req ? head.be   : '0;
  assign empty     = fifo_empty && !mem_req;

`ifdef STORE_FWD_EN
  logic unused_ld;
  assign unused_ld = ^ld_addr[1:0];

  // Scan oldest to youngest so the youngest matching word overrides earlier hits.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_be   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (ord[i].addr[A-1:2] == ld_addr[A-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = ord[i].data;
        fwd_be   = ord[i].be;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_store_writer.sv
// Scoreboard bench for mem_store_writer; build with STORE_FWD_EN to cover forwarding.
module tb_mem_store_writer;

  localparam int unsigned M = 32, A = 32, DEPTH = 4;

  logic          CLK, RST;
  logic          st_valid, st_ready;
  logic [A-1:0]  st_addr;
  logic [M-1:0]  st_data;
  logic [3:0]    st_be;
  logic          mem_req, mem_ack;
  logic [A-1:0]  mem_addr;
  logic [M-1:0]  mem_wdata;
  logic [3:0]    mem_be;
  logic [2:0]    count;
  logic          empty;
`ifdef STORE_FWD_EN
  logic [A-1:0]  ld_addr;
  logic          fwd_hit;
  logic [M-1:0]  fwd_data;
  logic [3:0]    fwd_be;
`endif

  typedef struct packed {
    logic [A-1:0] addr;
    logic [M-1:0] data;
    logic [3:0]   be;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_store_writer #(.M(M), .A(A), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .count    (count),
    .empty    (empty)
`ifdef STORE_FWD_EN
    ,
    .ld_addr  (ld_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .fwd_be   (fwd_be)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_store(input logic [A-1:0] a, input logic [M-1:0] d, input logic [3:0] b);
    int n = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = b;
    while (!st_ready && n < 50) begin tick(); n++; end
    if (!st_ready) chk("store_ready_timeout", 64'(st_ready), 64'd1);
    @(posedge CLK);
    if (b != 4'h0) sb.push_back('{addr: a, data: d, be: b});
    #1;
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    mem_ack = 1'b1;
    while (!empty && n < 50) begin tick(); n++; end
    mem_ack = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_sb_size", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every REQ cycle must present the oldest outstanding store; ack retires it.
  always @(negedge CLK) begin
    if (!RST && mem_req) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected_req: got addr 0x%0h with no store pending", mem_addr);
      end else if ({mem_addr, mem_wdata, mem_be} !== sb[0]) begin
        errors++;
        $display("FAIL mon_entry: got %h/%h/%h expected %h/%h/%h", mem_addr, mem_wdata, mem_be,
                 sb[0].addr, sb[0].data, sb[0].be);
      end
      if (mem_ack && sb.size() != 0) void'(sb.pop_front());
    end
  end

  initial begin
    RST = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0; mem_ack = 1'b0;
`ifdef STORE_FWD_EN
    ld_addr = '0;
`endif
    #3;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();
    RST = 1'b0;
    tick();

    // 1: single store, ack in the third REQ cycle
    do_store(32'h100, 32'hDEADBEEF, 4'hF);
    chk("t1_req_lat", 64'(mem_req), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_not_empty", 64'(empty), 64'd0);
    tick();
    chk("t1_req_c1", 64'(mem_req), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h100);
    tick();
    chk("t1_req_c2", 64'(mem_req), 64'd1);
    tick();
    chk("t1_req_c3", 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_req_done", 64'(mem_req), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_count_done", 64'(count), 64'd0);

    // 2: four back-to-back stores with ack held high
    mem_ack = 1'b1;
    do_store(32'h200, 32'h11111111, 4'hF);
    do_store(32'h204, 32'h22222222, 4'h3);
    do_store(32'h208, 32'h33333333, 4'hC);
    do_store(32'h20C, 32'h44444444, 4'h1);
    chk("t2_req_e3", 64'(mem_req), 64'd1);
    chk("t2_count_e3", 64'(count), 64'd2);
    tick();
    chk("t2_req_e4", 64'(mem_req), 64'd1);
    chk("t2_count_e4", 64'(count), 64'd1);
    tick();
    chk("t2_req_e5", 64'(mem_req), 64'd0);
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_sb", 64'(sb.size()), 64'd0);
    mem_ack = 1'b0;
    tick();

    // 3: fill without ack, fifth store held until a pop frees a slot
    do_store(32'h300, 32'hA0A0A0A0, 4'hF);
    do_store(32'h304, 32'hA1A1A1A1, 4'hF);
    do_store(32'h308, 32'hA2A2A2A2, 4'hF);
    do_store(32'h30C, 32'hA3A3A3A3, 4'hF);
    chk("t3_full_ready", 64'(st_ready), 64'd0);
    chk("t3_full_count", 64'(count), 64'd4);
    st_valid = 1'b1; st_addr = 32'h310; st_data = 32'hA4A4A4A4; st_be = 4'hF;
    tick();
    tick();
    chk("t3_held_count", 64'(count), 64'd4);
    chk("t3_held_ready", 64'(st_ready), 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t3_no_bypass", 64'(count), 64'd3);
    chk("t3_ready_back", 64'(st_ready), 64'd1);
    @(posedge CLK);
    sb.push_back('{addr: 32'h310, data: 32'hA4A4A4A4, be: 4'hF});
    #1;
    st_valid = 1'b0;
    chk("t3_accepted", 64'(count), 64'd4);
    drain();
    tick();

    // 4: zero byte-enable store is accepted but never written; stray ack ignored
    do_store(32'h400, 32'h55555555, 4'h0);
    chk("t4_count", 64'(count), 64'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_req", 64'(mem_req), 64'd0);
    end
    mem_ack = 1'b0;
    chk("t4_empty", 64'(empty), 64'd1);

    // 5: asynchronous reset in the middle of a request
    do_store(32'h500, 32'h01010101, 4'hF);
    do_store(32'h504, 32'h02020202, 4'hF);
    do_store(32'h508, 32'h03030303, 4'hF);
    chk("t5_req_before", 64'(mem_req), 64'd1);
    chk("t5_count_before", 64'(count), 64'd3);
    #2;
    RST = 1'b1;
    #1;
    sb.delete();
    chk("t5_req_rst", 64'(mem_req), 64'd0);
    chk("t5_count_rst", 64'(count), 64'd0);
    chk("t5_ready_rst", 64'(st_ready), 64'd1);
    chk("t5_empty_rst", 64'(empty), 64'd1);
    chk("t5_addr_rst", 64'(mem_addr), 64'd0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    chk("t5_req_after", 64'(mem_req), 64'd0);

`ifdef STORE_FWD_EN
    // 6: youngest matching pending store forwards
    do_store(32'h20, 32'h11, 4'hF);
    do_store(32'h20, 32'h22, 4'hF);
    ld_addr = 32'h22;
    #1;
    chk("t6_hit", 64'(fwd_hit), 64'd1);
    chk("t6_data", 64'(fwd_data), 64'h22);
    chk("t6_be", 64'(fwd_be), 64'hF);
    ld_addr = 32'h40;
    #1;
    chk("t6_miss", 64'(fwd_hit), 64'd0);
    chk("t6_miss_data", 64'(fwd_data), 64'd0);
    drain();
    ld_addr = 32'h20;
    #1;
    chk("t6_after_drain", 64'(fwd_hit), 64'd0);
`endif

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
